// File: rtl/alu_cmd_engine.sv
// Clocked command front-end for a 4-bit ALU: registers operands,
// waits a settle interval, then returns the captured result.
module alu_cmd_engine #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [1:0] cmd_sel,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_sel,
    input  logic [3:0] alu_result,
    input  logic       alu_carry,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_result,
    output logic       rsp_carry,
    output logic       busy,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RESPOND
    } state_e;

    localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

    state_e     state_q;
    logic [3:0] settle_q;
    logic [3:0] alu_a_q;
    logic [3:0] alu_b_q;
    logic [1:0] alu_sel_q;
    logic       rsp_valid_q;
    logic [3:0] rsp_result_q;
    logic       rsp_carry_q;
    logic [7:0] op_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            settle_q     <= 4'd0;
            alu_a_q      <= 4'd0;
            alu_b_q      <= 4'd0;
            alu_sel_q    <= 2'd0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 4'd0;
            rsp_carry_q  <= 1'b0;
            op_count_q   <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a_q   <= cmd_a;
                        alu_b_q   <= cmd_b;
                        alu_sel_q <= cmd_sel;
                        settle_q  <= 4'd0;
                        state_q   <= DRIVE;
                    end
                end
                DRIVE: begin
                    settle_q <= settle_q + 4'd1;
                    // Operands have been stable on the ALU for the full interval.
                    if (settle_q == LAST) begin
                        rsp_result_q <= alu_result;
                        rsp_carry_q  <= alu_carry;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + 8'd1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_cmd_engine.sv
// Bench for alu_cmd_engine: two engines (settle 1 and 4), each with
// its own behavioural ALU, checked every cycle against a reference.
module tb_alu_cmd_engine;

    localparam int S0 = 1;
    localparam int S1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       cv [2];
    logic       cr [2];
    logic [3:0] ca [2];
    logic [3:0] cb [2];
    logic [1:0] cs [2];
    logic [3:0] aa [2];
    logic [3:0] ab [2];
    logic [1:0] asel [2];
    logic [4:0] aluo [2];
    logic       rv [2];
    logic       rr [2];
    logic [3:0] rres [2];
    logic       rc [2];
    logic       bz [2];
    logic [7:0] oc [2];

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int hs [2];
    logic [4:0] rq0 [$];

    // ALU: 00 add, 01 sub (carry = borrow), 10 AND, 11 OR
    function automatic logic [4:0] alu_f(logic [3:0] a, logic [3:0] b,
                                         logic [1:0] s);
        case (s)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a} - {1'b0, b};
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    assign aluo[0] = alu_f(aa[0], ab[0], asel[0]);
    assign aluo[1] = alu_f(aa[1], ab[1], asel[1]);

    alu_cmd_engine #(.SETTLE_CYCLES(S0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cv[0]), .cmd_ready(cr[0]),
        .cmd_a(ca[0]), .cmd_b(cb[0]), .cmd_sel(cs[0]),
        .alu_a(aa[0]), .alu_b(ab[0]), .alu_sel(asel[0]),
        .alu_result(aluo[0][3:0]), .alu_carry(aluo[0][4]),
        .rsp_valid(rv[0]), .rsp_ready(rr[0]),
        .rsp_result(rres[0]), .rsp_carry(rc[0]),
        .busy(bz[0]), .op_count(oc[0])
    );

    alu_cmd_engine #(.SETTLE_CYCLES(S1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cv[1]), .cmd_ready(cr[1]),
        .cmd_a(ca[1]), .cmd_b(cb[1]), .cmd_sel(cs[1]),
        .alu_a(aa[1]), .alu_b(ab[1]), .alu_sel(asel[1]),
        .alu_result(aluo[1][3:0]), .alu_carry(aluo[1][4]),
        .rsp_valid(rv[1]), .rsp_ready(rr[1]),
        .rsp_result(rres[1]), .rsp_carry(rc[1]),
        .busy(bz[1]), .op_count(oc[1])
    );

    // Reference: an operation is "idle", "waiting" a number of edges,
    // or "holding" a result until taken.
    int         m_phase [2];
    int         m_left [2];
    logic [3:0] m_a [2];
    logic [3:0] m_b [2];
    logic [1:0] m_s [2];
    logic [4:0] m_rsp [2];
    logic       m_rv [2];
    logic [7:0] m_cnt [2];

    function automatic int settle(int i);
        return (i == 0) ? S0 : S1;
    endfunction

    always @(negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0;
            m_left[i]  = 0;
            m_a[i]     = 4'd0;
            m_b[i]     = 4'd0;
            m_s[i]     = 2'd0;
            m_rsp[i]   = 5'd0;
            m_rv[i]    = 1'b0;
            m_cnt[i]   = 8'd0;
        end
    end

    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (m_phase[i] == 0) begin
                    if (cv[i]) begin
                        m_a[i] = ca[i];
                        m_b[i] = cb[i];
                        m_s[i] = cs[i];
                        m_left[i] = settle(i);
                        m_phase[i] = 1;
                    end
                end else if (m_phase[i] == 1) begin
                    m_left[i] = m_left[i] - 1;
                    if (m_left[i] == 0) begin
                        m_rsp[i] = alu_f(m_a[i], m_b[i], m_s[i]);
                        m_rv[i] = 1'b1;
                        m_phase[i] = 2;
                    end
                end else if (rr[i]) begin
                    m_rv[i] = 1'b0;
                    m_cnt[i] = m_cnt[i] + 8'd1;
                    m_phase[i] = 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (rv[i] && rr[i]) begin
                    hs[i] = hs[i] + 1;
                    if (i == 0) rq0.push_back({rc[0], rres[0]});
                end
            end
        end
    end

    task automatic chk(input string nm, input int i,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h",
                     nm, i, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("cmd_ready", i, 32'(cr[i]), 32'(m_phase[i] == 0));
            chk("busy", i, 32'(bz[i]), 32'(m_phase[i] != 0));
            chk("alu_a", i, 32'(aa[i]), 32'(m_a[i]));
            chk("alu_b", i, 32'(ab[i]), 32'(m_b[i]));
            chk("alu_sel", i, 32'(asel[i]), 32'(m_s[i]));
            chk("rsp_valid", i, 32'(rv[i]), 32'(m_rv[i]));
            chk("rsp", i, 32'({rc[i], rres[i]}), 32'(m_rsp[i]));
            chk("op_count", i, 32'(oc[i]), 32'(m_cnt[i]));
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic do_cmd(input int i, input logic [3:0] a,
                          input logic [3:0] b, input logic [1:0] s,
                          output int acc);
        int n;
        n = 0;
        acc = -1;
        cv[i] = 1'b1;
        ca[i] = a;
        cb[i] = b;
        cs[i] = s;
        while (!cr[i] && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!cr[i]) begin
            chk("accept_timeout", i, 32'(cr[i]), 32'd1);
            return;
        end
        @(posedge clk);
        #1 acc = cyc;
        @(negedge clk);
    endtask

    task automatic wait_rv(input int i, input int bound);
        int n;
        n = 0;
        while (!rv[i] && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_wait", i, 32'(rv[i]), 32'd1);
    endtask

    int  k, t1, t2, t3, n, base0, base1;
    bit  rnd_on;

    initial begin
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cv[i] = 1'b0; ca[i] = 4'd0; cb[i] = 4'd0; cs[i] = 2'd0;
            rr[i] = 1'b0; hs[i] = 0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_cmd_ready", i, 32'(cr[i]), 32'd1);
            chk("rst_busy", i, 32'(bz[i]), 32'd0);
            chk("rst_rsp_valid", i, 32'(rv[i]), 32'd0);
            chk("rst_op_count", i, 32'(oc[i]), 32'd0);
            chk("rst_alu", i, 32'({aa[i], ab[i], asel[i]}), 32'd0);
        end
        rst_n = 1'b1;

        // single command
        rr[0] = 1'b1;
        do_cmd(0, 4'b0011, 4'b0010, 2'b00, k);
        cv[0] = 1'b0;
        chk("single_alu", 0, 32'({aa[0], ab[0], asel[0]}), 32'b0011_0010_00);
        chk("single_rv_early", 0, 32'(rv[0]), 32'd0);
        @(negedge clk);
        chk("single_rv", 0, 32'(rv[0]), 32'd1);
        chk("single_rsp", 0, 32'({rc[0], rres[0]}), 32'b0_0101);
        @(negedge clk);
        chk("single_done", 0, 32'(rv[0]), 32'd0);
        chk("single_count", 0, 32'(oc[0]), 32'd1);

        // back-to-back with cmd_valid held
        rq0.delete();
        do_cmd(0, 4'b0100, 4'b0001, 2'b01, t1);
        do_cmd(0, 4'b1100, 4'b1010, 2'b10, t2);
        do_cmd(0, 4'b1100, 4'b1010, 2'b11, t3);
        cv[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_gap1", 0, 32'(t2 - t1), 32'd3);
        chk("b2b_gap2", 0, 32'(t3 - t2), 32'd3);
        chk("b2b_nrsp", 0, 32'(rq0.size()), 32'd3);
        if (rq0.size() == 3) begin
            chk("b2b_r0", 0, 32'(rq0[0]), 32'h03);
            chk("b2b_r1", 0, 32'(rq0[1]), 32'h08);
            chk("b2b_r2", 0, 32'(rq0[2]), 32'h0E);
        end

        // backpressure
        rr[0] = 1'b0;
        do_cmd(0, 4'b0101, 4'b0110, 2'b00, k);
        cv[0] = 1'b0;
        wait_rv(0, 10);
        for (int j = 0; j < 5; j++) begin
            chk("bp_rv", 0, 32'(rv[0]), 32'd1);
            chk("bp_busy", 0, 32'(bz[0]), 32'd1);
            chk("bp_cmd_ready", 0, 32'(cr[0]), 32'd0);
            chk("bp_rsp", 0, 32'({rc[0], rres[0]}), 32'h0B);
            @(negedge clk);
        end
        rr[0] = 1'b1;
        @(negedge clk);
        chk("bp_done", 0, 32'(rv[0]), 32'd0);
        chk("bp_count", 0, 32'(oc[0]), 32'd5);

        // settle of 4, inputs disturbed during DRIVE
        rr[1] = 1'b1;
        do_cmd(1, 4'b1111, 4'b0001, 2'b00, k);
        cv[1] = 1'b0; ca[1] = 4'd0; cb[1] = 4'd9; cs[1] = 2'd3;
        n = 0;
        while (!rv[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("s4_latency", 1, 32'(n), 32'd4);
        chk("s4_alu", 1, 32'({aa[1], ab[1], asel[1]}), 32'b1111_0001_00);
        chk("s4_rsp", 1, 32'({rc[1], rres[1]}), 32'h10);
        @(negedge clk);

        // reset mid-DRIVE
        do_cmd(1, 4'b0111, 4'b0111, 2'b00, k);
        cv[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rv", 1, 32'(rv[1]), 32'd0);
        chk("mid_rst_count", 1, 32'(oc[1]), 32'd0);
        chk("mid_rst_alu", 1, 32'({aa[1], ab[1], asel[1]}), 32'd0);
        chk("mid_rst_ready", 1, 32'(cr[1]), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base1 = hs[1];
        repeat (8) @(negedge clk);
        chk("mid_rst_norsp", 1, 32'(hs[1] - base1), 32'd0);

        // randomized traffic; 256 ops on engine 0 wraps op_count
        base0 = hs[0];
        base1 = hs[1];
        rnd_on = 1'b1;
        fork
            begin
                fork
                    begin
                        int a0;
                        for (int j = 0; j < 256; j++) begin
                            do_cmd(0, 4'($urandom_range(0, 15)),
                                   4'($urandom_range(0, 15)),
                                   2'($urandom_range(0, 3)), a0);
                            cv[0] = 1'b0;
                            repeat ($urandom_range(0, 2)) @(negedge clk);
                        end
                    end
                    begin
                        int a1;
                        for (int j = 0; j < 40; j++) begin
                            do_cmd(1, 4'($urandom_range(0, 15)),
                                   4'($urandom_range(0, 15)),
                                   2'($urandom_range(0, 3)), a1);
                            cv[1] = 1'b0;
                            ca[1] = 4'($urandom_range(0, 15));
                            repeat ($urandom_range(0, 3)) @(negedge clk);
                        end
                    end
                join
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(negedge clk);
                    rr[0] = 1'($urandom_range(0, 1));
                    rr[1] = 1'($urandom_range(0, 1));
                end
            end
        join
        rr[0] = 1'b1;
        rr[1] = 1'b1;
        n = 0;
        while ((hs[0] - base0 < 256 || hs[1] - base1 < 40) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("wrap_ops", 0, 32'(hs[0] - base0), 32'd256);
        chk("wrap_count", 0, 32'(oc[0]), 32'd0);
        chk("rand_count", 1, 32'(oc[1]), 32'd40);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
